pipe_hazard_ctrl: RTL and testbench

// Parametrised hazard/forwarding controller for the pipelined MIPS core; replaces per-design ad-hoc hazard and forward logic.

---
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight writers past decode, emits stall/bubble/flush and forward selects.
// Optional build macro PIPE_HAZARD_STATS_EN adds stall_cnt_o/flush_cnt_o saturating counters.

module phc_stage_match #(
  parameter int REG_AW = 5
) (
  input  logic              vld_i,
  input  logic              wen_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] ra_i,
  input  logic [REG_AW-1:0] rb_i,
  output logic              hit_a_o,
  output logic              hit_b_o
);
  logic wr;
  assign wr      = vld_i & wen_i;
  assign hit_a_o = wr & (rd_i == ra_i) & (ra_i != '0);
  assign hit_b_o = wr & (rd_i == rb_i) & (rb_i != '0);
endmodule

module pipe_hazard_ctrl #(
  parameter  int REG_AW     = 5,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_AVAIL = 2,
  localparam int SEL_W      = $clog2(DEPTH+1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              d_valid_i,
  input  logic [REG_AW-1:0] d_rs_i,
  input  logic [REG_AW-1:0] d_rt_i,
  input  logic [REG_AW-1:0] d_rd_i,
  input  logic              d_wen_i,
  input  logic              d_load_i,
  input  logic              redirect_i,
  input  logic              ex_busy_i,
`ifdef PIPE_HAZARD_STATS_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              bubble_e_o,
  output logic              flush_d_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              load;
  } ent_t;

  logic [DEPTH:1] vld_pipe_q, vld_pipe_d;
  ent_t           ent_q [DEPTH:1];
  ent_t           ent_d [DEPTH:1];
  logic [DEPTH:1] hit_a, hit_b;

  for (genvar g = 1; g <= DEPTH; g++) begin : g_stage
    phc_stage_match #(.REG_AW(REG_AW)) u_match (
      .vld_i   (vld_pipe_q[g]),
      .wen_i   (ent_q[g].wen),
      .rd_i    (ent_q[g].rd),
      .ra_i    (d_rs_i),
      .rb_i    (d_rt_i),
      .hit_a_o (hit_a[g]),
      .hit_b_o (hit_b[g])
    );
  end

  // Walk oldest to youngest so the youngest matching writer overrides.
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             lu_a, lu_b, load_use;
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit_a[k]) begin
        sel_a = SEL_W'(k);
        lu_a  = ent_q[k].load && (k < LOAD_AVAIL);
      end
      if (hit_b[k]) begin
        sel_b = SEL_W'(k);
        lu_b  = ent_q[k].load && (k < LOAD_AVAIL);
      end
    end
  end

  assign load_use = d_valid_i & (lu_a | lu_b);

  logic stall, bubble, flush;
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (ex_busy_i) begin
      stall = 1'b1;
    end else if (redirect_i) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (load_use) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  // Outputs are forced low while reset is held, whatever the other inputs do.
  assign stall_f_o  = reset_i & stall;
  assign stall_d_o  = reset_i & stall;
  assign bubble_e_o = reset_i & bubble;
  assign flush_d_o  = reset_i & flush;
  assign fwd_a_o    = (reset_i & d_valid_i) ? sel_a : '0;
  assign fwd_b_o    = (reset_i & d_valid_i) ? sel_b : '0;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    ent_d      = ent_q;
    for (int k = 2; k <= DEPTH; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      ent_d[k]      = ent_q[k-1];
    end
    if (ex_busy_i) begin
      // E holds its instruction; M receives a bubble.
      vld_pipe_d[1] = vld_pipe_q[1];
      ent_d[1]      = ent_q[1];
      vld_pipe_d[2] = 1'b0;
      ent_d[2]      = '0;
    end else if (redirect_i || load_use) begin
      vld_pipe_d[1] = 1'b0;
      ent_d[1]      = '0;
    end else begin
      vld_pipe_d[1] = d_valid_i;
      ent_d[1].rd   = d_rd_i;
      ent_d[1].wen  = d_wen_i;
      ent_d[1].load = d_load_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      vld_pipe_q <= '0;
      for (int k = 1; k <= DEPTH; k++) ent_q[k] <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      for (int k = 1; k <= DEPTH; k++) ent_q[k] <= ent_d[k];
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f_o && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_d_o && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + random bench for pipe_hazard_ctrl against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;
  localparam int D  = 3;
  localparam int LA = 2;
  localparam int SW = $clog2(D+1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          d_valid_i = 1'b0, d_wen_i = 1'b0, d_load_i = 1'b0;
  logic [AW-1:0] d_rs_i = '0, d_rt_i = '0, d_rd_i = '0;
  logic          redirect_i = 1'b0, ex_busy_i = 1'b0;
  logic          stall_f_o, stall_d_o, bubble_e_o, flush_d_o;
  logic [SW-1:0] fwd_a_o, fwd_b_o;
`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0]   stall_cnt_o, flush_cnt_o;
`endif

  pipe_hazard_ctrl #(.REG_AW(AW), .DEPTH(D), .LOAD_AVAIL(LA)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .d_valid_i(d_valid_i), .d_rs_i(d_rs_i), .d_rt_i(d_rt_i), .d_rd_i(d_rd_i),
    .d_wen_i(d_wen_i), .d_load_i(d_load_i), .redirect_i(redirect_i), .ex_busy_i(ex_busy_i),
`ifdef PIPE_HAZARD_STATS_EN
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .stall_f_o(stall_f_o), .stall_d_o(stall_d_o), .bubble_e_o(bubble_e_o),
    .flush_d_o(flush_d_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference: pipe[k] is the instruction k stages past decode.
  typedef struct {
    bit          v;
    bit [AW-1:0] rd;
    bit          wen;
    bit          ld;
  } ins_t;
  ins_t  pipe [1:D];
  ins_t  nop;
  bit    cur_lu;
  longint exp_scnt = 0, exp_fcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int youngest(input bit [AW-1:0] r);
    for (int k = 1; k <= D; k++)
      if (pipe[k].v && pipe[k].wen && pipe[k].rd == r && r != 0) return k;
    return 0;
  endfunction

  task automatic drive(input bit rst, input bit v, input bit [AW-1:0] rs, input bit [AW-1:0] rt,
                       input bit [AW-1:0] rd, input bit wen, input bit ld, input bit rdr, input bit busy);
    int ka, kb;
    bit lu;
    reset_i = rst; d_valid_i = v; d_rs_i = rs; d_rt_i = rt; d_rd_i = rd;
    d_wen_i = wen; d_load_i = ld; redirect_i = rdr; ex_busy_i = busy;
    #2;
    ka = 0; kb = 0;
    if (rst && v) begin
      ka = youngest(rs);
      kb = youngest(rt);
    end
    lu = (ka != 0 && pipe[ka].ld && ka < LA) || (kb != 0 && pipe[kb].ld && kb < LA);
    cur_lu = lu;
    chk("stall_f",  {31'd0, stall_f_o},  {31'd0, rst && (busy || (!rdr && lu))});
    chk("stall_d",  {31'd0, stall_d_o},  {31'd0, rst && (busy || (!rdr && lu))});
    chk("bubble_e", {31'd0, bubble_e_o}, {31'd0, rst && !busy && (rdr || lu)});
    chk("flush_d",  {31'd0, flush_d_o},  {31'd0, rst && !busy && rdr});
    chk("fwd_a",    32'(fwd_a_o), 32'(ka));
    chk("fwd_b",    32'(fwd_b_o), 32'(kb));
  endtask

  task automatic tick();
    @(posedge clk_i);
    if (!reset_i) begin
      for (int k = 1; k <= D; k++) pipe[k] = nop;
      exp_scnt = 0; exp_fcnt = 0;
    end else if (ex_busy_i) begin
      for (int k = D; k >= 3; k--) pipe[k] = pipe[k-1];
      pipe[2] = nop;
      exp_scnt++;
    end else begin
      for (int k = D; k >= 2; k--) pipe[k] = pipe[k-1];
      if (redirect_i || cur_lu) pipe[1] = nop;
      else pipe[1] = '{d_valid_i, d_rd_i, d_wen_i, d_load_i};
      if (redirect_i) exp_fcnt++;
      else if (cur_lu) exp_scnt++;
    end
    #1;
`ifdef PIPE_HAZARD_STATS_EN
    chk("stall_cnt", stall_cnt_o, 32'(exp_scnt));
    chk("flush_cnt", flush_cnt_o, 32'(exp_fcnt));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nop = '{0, 0, 0, 0};
    for (int k = 1; k <= D; k++) pipe[k] = nop;
    @(posedge clk_i); #1;

    // reset holds every output low, even with redirect/busy asserted
    drive(0, 1, 5, 0, 0, 0, 0, 1, 1);
    chk("t1_fwd_a_rst", 32'(fwd_a_o), 0);
    chk("t1_stall_rst", {31'd0, stall_f_o}, 0);
    tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
    chk("t1_fwd_a_rel", 32'(fwd_a_o), 0);
    tick();

    // ALU forwarding from E then M
    drive(1, 1, 0, 0, 8, 1, 0, 0, 0); tick();
    drive(1, 1, 8, 0, 0, 0, 0, 0, 0); chk("t2_fwd_e", 32'(fwd_a_o), 1); tick();
    drive(1, 1, 8, 0, 0, 0, 0, 0, 0); chk("t2_fwd_m", 32'(fwd_a_o), 2); tick();

    // youngest writer wins
    drive(1, 1, 0, 0, 9, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 9, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 9, 0, 0, 0, 0, 0); chk("t3_young", 32'(fwd_b_o), 1); tick();

    // load-use: one stall cycle, then forward from M
    drive(1, 1, 0, 0, 4, 1, 1, 0, 0); tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
    chk("t4_stall", {31'd0, stall_f_o}, 1);
    chk("t4_bubble", {31'd0, bubble_e_o}, 1);
    tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
    chk("t4_fwd", 32'(fwd_a_o), 2);
    chk("t4_nostall", {31'd0, stall_f_o}, 0);
    tick();

    // redirect beats load-use; r0 never forwards
    drive(1, 1, 0, 0, 4, 1, 1, 0, 0); tick();
    drive(1, 1, 4, 0, 0, 0, 0, 1, 0);
    chk("t5_flush", {31'd0, flush_d_o}, 1);
    chk("t5_stall", {31'd0, stall_f_o}, 0);
    tick();
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); chk("t5_r0", 32'(fwd_a_o), 0); tick();

    // reset mid-stall empties the tracker
    drive(1, 1, 0, 0, 4, 1, 1, 0, 0); tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 4, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_stall", {31'd0, stall_f_o}, 0);
    tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_fwd", 32'(fwd_a_o), 0);
    tick();

    // ex_busy for 3 cycles: E held, M advances then drops off
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 10, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 11, 1, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 11, 10, 0, 0, 0, 0, 1);
      chk("t6_busy_stall", {31'd0, stall_f_o}, 1);
      chk("t6_hold_e", 32'(fwd_a_o), 1);
      tick();
    end
`ifdef PIPE_HAZARD_STATS_EN
    chk("t6_stall_cnt", stall_cnt_o, 3);
`endif
    drive(1, 1, 11, 10, 0, 0, 0, 0, 0); chk("t6_after", 32'(fwd_b_o), 0); tick();

    // random traffic over a tiny register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
            AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
